// File: rtl/svm_linear_accum_if.sv
// Beat and result bundle for the streaming linear-SVM scoring engine.
// Parameters must match the engine instance the interface is bound to.
interface svm_linear_accum_if #(
  parameter int N_FEAT = 3780,
  parameter int LANES  = 1,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 76
);
  localparam int BEATS  = N_FEAT / LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);

  logic                      iStart;
  logic                      iValid;
  logic                      oReady;
  logic [LANES*DATA_W-1:0]   iHOG;
  logic [LANES*DATA_W-1:0]   iTrained;
  logic [DATA_W-1:0]         iBias;
  logic [ACC_W-1:0]          oScore;
  logic                      oHUMAN;
  logic                      oFINISH;
  logic                      oBusy;
  logic [BEAT_W-1:0]         oBeat;

  modport master (
    output iStart, iValid, iHOG, iTrained, iBias,
    input  oReady, oScore, oHUMAN, oFINISH, oBusy, oBeat
  );

  modport slave (
    input  iStart, iValid, iHOG, iTrained, iBias,
    output oReady, oScore, oHUMAN, oFINISH, oBusy, oBeat
  );
endinterface

// File: rtl/svm_linear_accum.sv
// Streaming linear-SVM scorer: LANES feature*weight products per beat, a
// registered multiply stage, a registered lane-sum stage, then accumulate.
module svm_linear_accum #(
  parameter int N_FEAT = 3780,
  parameter int LANES  = 1,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 76
) (
  input  logic              iClk,
  input  logic              iRst_n,
  svm_linear_accum_if.slave bus
);
  localparam int BEATS  = N_FEAT / LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_RESULT
  } state_e;

  state_e                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      finish_q, finish_d;
  logic                      human_q, human_d;
  logic                      p1_vld_q, p1_vld_d;
  logic                      p2_vld_q, p2_vld_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic signed [DATA_W-1:0]  bias_q, bias_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   score_q, score_d;
  logic signed [ACC_W-1:0]   sum_q, sum_d;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [PROD_W-1:0]  prod_q [LANES];
  logic signed [PROD_W-1:0]  prod_d [LANES];
  logic                      accept;

  function automatic logic signed [PROD_W-1:0] mul_lane(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return PROD_W'(a) * PROD_W'(b);
  endfunction

  // A start in the same cycle as a beat wins; the beat is dropped.
  assign accept   = ready_q && bus.iValid && !bus.iStart;
  assign bias_ext = ACC_W'(bias_q) <<< FRAC_W;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod_d[l] = mul_lane(bus.iHOG[l*DATA_W +: DATA_W],
                           bus.iTrained[l*DATA_W +: DATA_W]);
    end
  end

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    sum_d = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_d = sum_d + ACC_W'(prod_q[l]);
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    bias_d   = bias_q;
    acc_d    = acc_q;
    score_d  = score_q;
    human_d  = human_q;
    finish_d = 1'b0;
    p1_vld_d = accept;
    p2_vld_d = p1_vld_q;

    if (p2_vld_q) begin
      acc_d = acc_q + sum_q;
    end

    case (state_q)
      S_IDLE: ;
      S_ACCUM: begin
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!p1_vld_q && !p2_vld_q) begin
          state_d  = S_RESULT;
          score_d  = acc_q + bias_ext;
          human_d  = !score_d[ACC_W-1] && (score_d != '0);
          finish_d = 1'b1;
        end
      end
      S_RESULT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Restart discards everything in flight but leaves the last score visible.
    if (bus.iStart) begin
      state_d  = S_ACCUM;
      beat_d   = '0;
      acc_d    = '0;
      bias_d   = bus.iBias;
      p1_vld_d = 1'b0;
      p2_vld_d = 1'b0;
      finish_d = 1'b0;
      score_d  = score_q;
      human_d  = human_q;
    end

    ready_d = (state_d == S_ACCUM);
    busy_d  = (state_d != S_IDLE);
  end

  // NOTE: only non-blocking assignments here, so all flops see pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      human_q  <= 1'b0;
      p1_vld_q <= 1'b0;
      p2_vld_q <= 1'b0;
      beat_q   <= '0;
      bias_q   <= '0;
      acc_q    <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      human_q  <= human_d;
      p1_vld_q <= p1_vld_d;
      p2_vld_q <= p2_vld_d;
      beat_q   <= beat_d;
      bias_q   <= bias_d;
      acc_q    <= acc_d;
      score_q  <= score_d;
    end
  end

  // NOTE: pipeline data regs are not reset; p1_vld_q/p2_vld_q qualify their contents.
  always_ff @(posedge iClk) begin
    if (accept) begin
      prod_q <= prod_d;
    end
    if (p1_vld_q) begin
      sum_q <= sum_d;
    end
  end

  assign bus.oReady  = ready_q;
  assign bus.oBusy   = busy_q;
  assign bus.oFINISH = finish_q;
  assign bus.oHUMAN  = human_q;
  assign bus.oScore  = score_q;
  assign bus.oBeat   = beat_q;

endmodule

// File: tb/tb_svm_linear_accum.sv
// Self-checking bench: three engine configurations against an exact
// wide-integer dot-product model with randomized data and valid gaps.
module tb_svm_linear_accum;
  localparam int ACC_W = 76;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b1;
  int   cyc    = 0;

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc++;

  svm_linear_accum_if #(.N_FEAT(4), .LANES(1), .DATA_W(32), .ACC_W(ACC_W)) ia ();
  svm_linear_accum_if #(.N_FEAT(8), .LANES(4), .DATA_W(32), .ACC_W(ACC_W)) ib ();
  svm_linear_accum_if #(.N_FEAT(3780), .LANES(1), .DATA_W(32), .ACC_W(ACC_W)) ic ();

  svm_linear_accum #(.N_FEAT(4), .LANES(1), .DATA_W(32), .FRAC_W(16), .ACC_W(ACC_W))
    dut_a (.iClk(iClk), .iRst_n(iRst_n), .bus(ia));
  svm_linear_accum #(.N_FEAT(8), .LANES(4), .DATA_W(32), .FRAC_W(16), .ACC_W(ACC_W))
    dut_b (.iClk(iClk), .iRst_n(iRst_n), .bus(ib));
  svm_linear_accum #(.N_FEAT(3780), .LANES(1), .DATA_W(32), .FRAC_W(16), .ACC_W(ACC_W))
    dut_c (.iClk(iClk), .iRst_n(iRst_n), .bus(ic));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Finish-pulse counters, and a record that C's score only moves on oFINISH.
  int               fin_a = 0, fin_b = 0, fin_c = 0, held_err_c = 0;
  logic [ACC_W-1:0] held_c = '0;
  logic             held_h_c = 1'b0;

  always @(negedge iClk) begin
    if (ia.oFINISH === 1'b1) fin_a++;
    if (ib.oFINISH === 1'b1) fin_b++;
    if (ic.oFINISH === 1'b1) begin
      fin_c++;
      held_c   = ic.oScore;
      held_h_c = ic.oHUMAN;
    end else if (ic.oScore !== held_c || ic.oHUMAN !== held_h_c) begin
      held_err_c++;
    end
  end

  always @(negedge iRst_n) begin
    held_c   = '0;
    held_h_c = 1'b0;
  end

  task automatic run_a(input logic [31:0] bias, input logic [31:0] f0, input logic [31:0] w0,
                       input bit rnd, input string tag);
    logic signed [127:0] m;
    logic [31:0] f, w;
    int n, first, fin0, uerr, berr, rerr;
    bit done;
    m = longint'($signed(bias)) * 65536;
    n = 0; first = -1; uerr = 0; berr = 0; rerr = 0; done = 1'b0;
    fin0 = fin_a;
    @(negedge iClk);
    ia.iStart = 1'b1; ia.iBias = bias; ia.iValid = 1'b0;
    @(negedge iClk);
    ia.iStart = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (ia.oBusy !== 1'b1) uerr++;
      if (int'(ia.oBeat) != n) berr++;
      if (ia.oReady !== (n < 4)) rerr++;
      if (ia.oFINISH === 1'b1) done = 1'b1;
      else begin
        f = rnd ? $urandom : f0;
        w = rnd ? $urandom : w0;
        ia.iValid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
        ia.iHOG = f; ia.iTrained = w;
        if (ia.iValid && n < 4) begin
          if (n == 0) first = cyc;
          n++;
          m = m + longint'($signed(f)) * longint'($signed(w));
        end
        @(negedge iClk);
      end
    end
    check({tag, ":finish"}, ia.oFINISH, 1);
    check({tag, ":score"}, ia.oScore, m[ACC_W-1:0]);
    check({tag, ":human"}, ia.oHUMAN, m > 0);
    check({tag, ":busy_err"}, uerr, 0);
    check({tag, ":beat_err"}, berr, 0);
    check({tag, ":ready_err"}, rerr, 0);
    if (!rnd) check({tag, ":latency"}, cyc - first, 4 + 3);
    ia.iValid = 1'b0;
    @(negedge iClk);
    check({tag, ":busy_after"}, ia.oBusy, 0);
    repeat (3) @(negedge iClk);
    check({tag, ":n_finish"}, fin_a - fin0, 1);
  endtask

  task automatic run_b(input logic [31:0] bias, input bit rnd, input string tag);
    logic signed [127:0] m;
    logic [127:0] hv, wv;
    int n, first, fin0, uerr, rerr;
    bit done;
    m = longint'($signed(bias)) * 65536;
    n = 0; first = -1; uerr = 0; rerr = 0; done = 1'b0;
    fin0 = fin_b;
    @(negedge iClk);
    ib.iStart = 1'b1; ib.iBias = bias; ib.iValid = 1'b0;
    @(negedge iClk);
    ib.iStart = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (ib.oBusy !== 1'b1) uerr++;
      if (int'(ib.oBeat) != n || ib.oReady !== (n < 2)) rerr++;
      if (ib.oFINISH === 1'b1) done = 1'b1;
      else begin
        for (int l = 0; l < 4; l++) begin
          hv[l*32 +: 32] = rnd ? $urandom : 32'((n * 4 + l + 1) << 16);
          wv[l*32 +: 32] = rnd ? $urandom : 32'h0001_0000;
        end
        ib.iValid = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
        ib.iHOG = hv; ib.iTrained = wv;
        if (ib.iValid && n < 2) begin
          if (n == 0) first = cyc;
          n++;
          for (int l = 0; l < 4; l++)
            m = m + longint'($signed(hv[l*32 +: 32])) * longint'($signed(wv[l*32 +: 32]));
        end
        @(negedge iClk);
      end
    end
    check({tag, ":finish"}, ib.oFINISH, 1);
    check({tag, ":score"}, ib.oScore, m[ACC_W-1:0]);
    check({tag, ":human"}, ib.oHUMAN, m > 0);
    check({tag, ":busy_err"}, uerr, 0);
    check({tag, ":beat_ready_err"}, rerr, 0);
    if (!rnd) check({tag, ":latency"}, cyc - first, 2 + 3);
    ib.iValid = 1'b0;
    repeat (4) @(negedge iClk);
    check({tag, ":n_finish"}, fin_b - fin0, 1);
  endtask

  // Window on the full-size engine; stop_at beats then abandon if !want_fin.
  task automatic run_c(input logic [31:0] bias, input int stop_at, input bit want_fin,
                       input string tag);
    logic signed [127:0] m;
    logic [31:0] f, w;
    int n, uerr, berr, rerr;
    bit done;
    m = longint'($signed(bias)) * 65536;
    n = 0; uerr = 0; berr = 0; rerr = 0; done = 1'b0;
    @(negedge iClk);
    ic.iStart = 1'b1; ic.iBias = bias;
    ic.iValid = 1'b1; ic.iHOG = $urandom; ic.iTrained = $urandom;
    @(negedge iClk);
    ic.iStart = 1'b0;
    for (int k = 0; k < 20000 && !done; k++) begin
      if (ic.oBusy !== 1'b1) uerr++;
      if (int'(ic.oBeat) != n) berr++;
      if (ic.oReady !== (n < 3780)) rerr++;
      if (ic.oFINISH === 1'b1 || (!want_fin && n == stop_at)) done = 1'b1;
      else begin
        f = $urandom; w = $urandom;
        ic.iValid = 1'($urandom_range(1, 0));
        ic.iHOG = f; ic.iTrained = w;
        if (ic.iValid && n < 3780) begin
          n++;
          m = m + longint'($signed(f)) * longint'($signed(w));
        end
        @(negedge iClk);
      end
    end
    check({tag, ":busy_err"}, uerr, 0);
    check({tag, ":beat_err"}, berr, 0);
    check({tag, ":ready_err"}, rerr, 0);
    if (want_fin) begin
      check({tag, ":finish"}, ic.oFINISH, 1);
      check({tag, ":score"}, ic.oScore, m[ACC_W-1:0]);
      check({tag, ":human"}, ic.oHUMAN, m > 0);
      ic.iValid = 1'b0;
      @(negedge iClk);
      check({tag, ":busy_after"}, ic.oBusy, 0);
    end else begin
      check({tag, ":beats_reached"}, n, stop_at);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    int fin0;
    ia.iStart = 1'b0; ia.iValid = 1'b0; ia.iHOG = '0; ia.iTrained = '0; ia.iBias = '0;
    ib.iStart = 1'b0; ib.iValid = 1'b0; ib.iHOG = '0; ib.iTrained = '0; ib.iBias = '0;
    ic.iStart = 1'b0; ic.iValid = 1'b0; ic.iHOG = '0; ic.iTrained = '0; ic.iBias = '0;
    #1 iRst_n = 1'b0;
    repeat (3) @(negedge iClk);
    check("reset:ready",  ia.oReady,  0);
    check("reset:score",  ia.oScore,  0);
    check("reset:human",  ia.oHUMAN,  0);
    check("reset:finish", ia.oFINISH, 0);
    check("reset:busy",   ia.oBusy,   0);
    check("reset:beat",   ia.oBeat,   0);
    iRst_n = 1'b1;
    repeat (2) @(negedge iClk);

    run_a(32'h0000_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, "a_bias0");
    run_a(32'hFFFB_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, "a_bias_m5");
    run_a(32'hFFFC_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, "a_bias_m4");
    run_a($urandom, 32'h0, 32'h0, 1'b1, "a_rnd");

    // Asynchronous reset in the middle of a window.
    @(negedge iClk);
    ia.iStart = 1'b1; ia.iBias = 32'h0001_0000;
    @(negedge iClk);
    ia.iStart = 1'b0; ia.iValid = 1'b1;
    ia.iHOG = 32'h0001_0000; ia.iTrained = 32'h0001_0000;
    repeat (2) @(negedge iClk);
    fin0 = fin_a;
    #2 iRst_n = 1'b0;
    #1;
    check("rst:busy",   ia.oBusy,   0);
    check("rst:ready",  ia.oReady,  0);
    check("rst:beat",   ia.oBeat,   0);
    check("rst:score",  ia.oScore,  0);
    check("rst:human",  ia.oHUMAN,  0);
    check("rst:finish", ia.oFINISH, 0);
    ia.iValid = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    repeat (12) @(negedge iClk);
    check("rst:no_finish", fin_a - fin0, 0);
    check("rst:score_kept", ia.oScore, 0);
    run_a(32'h0002_0000, 32'h0001_0000, 32'h0003_0000, 1'b0, "a_post_rst");

    run_b(32'h0000_0000, 1'b0, "b_seq");
    run_b($urandom, 1'b1, "b_rnd");

    run_c($urandom, 3780, 1'b1, "c_full");
    fin0 = fin_c;
    run_c($urandom, 2000, 1'b0, "c_abort");
    run_c($urandom, 3780, 1'b1, "c_restart");
    repeat (4) @(negedge iClk);
    check("c:n_finish", fin_c - fin0, 1);
    check("c:held_err", held_err_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/svm_linear_accum.md
Name: svm_linear_accum

Overview:
- Parametrised streaming linear-SVM scoring engine. Successor to the current fixed 3780-value SVM classifier.
- Accepts normalised HOG descriptor values and trained weights, LANES pairs per beat, over a valid/ready handshake.
- Accumulates the full-precision dot product, adds a Q-format bias and emits a signed score, a human/non-human decision and a one-cycle finish pulse.
- Sits between the HOG descriptor buffer / address generator and the detection output logic; restartable per detection window.

Parameters:
- N_FEAT, 3780: descriptor length per window; must be a multiple of LANES.
- LANES, 1: feature/weight pairs consumed per accepted beat (1, 2, 4, 9, 36 legal).
- DATA_W, 32: signed width of each feature, weight and bias.
- FRAC_W, 16: fractional bits of feature, weight and bias (Q format).
- ACC_W, 76: signed accumulator/score width; must be ≥ 2*DATA_W + clog2(N_FEAT).

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iStart  in  1  one-cycle pulse: begin a new window (clears accumulator and beat count).
- iValid  in  1  iHOG/iTrained hold a valid beat.
- oReady  out  1  engine accepts a beat this cycle.
- iHOG  in  LANES*DATA_W  packed signed features; lane 0 in LSBs.
- iTrained  in  LANES*DATA_W  packed signed weights, lane-aligned with iHOG.
- iBias  in  DATA_W  signed bias, Q(FRAC_W); sampled on the cycle iStart is accepted.
- oScore  out  ACC_W  signed score, Q(2*FRAC_W).
- oHUMAN  out  1  1 when oScore > 0.
- oFINISH  out  1  one-cycle pulse when oScore/oHUMAN update.
- oBusy  out  1  high from accepted iStart until oFINISH inclusive.
- oBeat  out  clog2(N_FEAT/LANES+1)  beats accepted in the current window.

Behaviour:
- Reset (async assert, sync release): state IDLE; oReady 0; oScore 0; oHUMAN 0; oFINISH 0; oBusy 0; oBeat 0; pipeline valid bits 0.
- States: IDLE, ACCUM, DRAIN, RESULT.
  - IDLE: iStart moves to ACCUM.
  - ACCUM: oReady=1. A beat is accepted when iValid&&oReady. After beat N_FEAT/LANES is accepted, move to DRAIN.
  - DRAIN: wait until the multiply and accumulate stages are empty, then move to RESULT.
  - RESULT: one cycle; oFINISH=1; return to IDLE.
- iStart from any state, including ACCUM/DRAIN:
  - zeroes the accumulator and oBeat, and clears the pipeline valid bits, discarding in-flight products;
  - latches iBias and goes to ACCUM on the next edge.
  - If it coincides with an accepted beat, start wins and the beat is discarded.
  - If it coincides with RESULT, oFINISH still pulses with the old result, then the new window starts.
- Pipeline:
  - Stage 1 registers the LANES signed DATA_W×DATA_W products (2*DATA_W each).
  - Stage 2 adds their sign-extended sum to the ACC_W accumulator.
  - If the last beat is accepted on edge T, the accumulator is final at T+2. oScore = acc + (sign-extended bias <<< FRAC_W) is registered at T+3, with oFINISH high for the cycle following edge T+3.
  - Minimum window latency with iValid held high: N_FEAT/LANES + 3 cycles after the first accepted beat.
- iValid gaps in ACCUM: stall only; no accumulation; oBeat holds.
- iValid outside ACCUM: ignored.
- Arithmetic: all values two's complement. Accumulator wraps silently at ACC_W (the parameter rule guarantees no overflow). oHUMAN is a strict compare, so a score of exactly 0 gives oHUMAN=0.
- oScore/oHUMAN hold their last values until the next oFINISH. iStart does not clear them.
- oBeat saturates at N_FEAT/LANES until the next iStart.

Test Plan:
- N_FEAT=4, LANES=1: iStart with iBias=0, then 4 beats of iHOG=iTrained=0x00010000 with iValid held high → oScore=4<<32=0x4_0000_0000, oHUMAN=1, oFINISH exactly 4+3 cycles after the first accepted beat, oBusy high throughout.
- Same stimulus with iBias=0xFFFB0000 (−5.0) → oScore=−1.0 in Q32 (=−0x1_0000_0000 sign-extended), oHUMAN=0. With iBias=0xFFFC0000 (−4.0) → oScore=0, oHUMAN=0.
- iValid toggled randomly (~50%) over a 3780-beat window with random data → oScore matches the bench's exact integer dot-product model; oBeat increments only on accepted beats; exactly one oFINISH.
- Second iStart after 2000 beats of a window, then a full clean window → one oFINISH only, with the score of the second window alone; oScore/oHUMAN unchanged before it.
- LANES=4, N_FEAT=8: two beats whose lanes carry features 1..8 (×1.0 Q16) and weights all 0x00010000 → oScore=36<<32, oHUMAN=1.
- iRst_n asserted for one cycle mid-window, then a fresh window → all outputs 0 immediately (asynchronous); no oFINISH from the aborted window; the fresh window scores correctly.
